branch_predictor: RTL and testbench
===================================

# branch_predictor

Produces the fetch stage's next-PC select and predicted target: the other end of the `pc_src`/`pred_pc_target` interface that the fetch PC mux consumes. It holds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, predicts in fetch, and resolves and updates in execute. It overrides a fetch prediction when execute detects a mispredict, and keeps branch and mispredict statistics counters.

## Interface
- `ENTRIES`, 64: BTB entries; power of two; index = `pc[IDX_W+1:2]`, `IDX_W = $clog2(ENTRIES)`.
- `CNT_W`, 32: width of the statistics counters.

Ports (name, direction, width, meaning):
- `clk_i` in 1: the only clock.
- `reset_i` in 1: synchronous, active-high reset.
- `pc_fi_i` in 32: fetch PC, used for lookup.
- `stall_ex_i` in 1: EX stage stalled; suppresses update, statistics and resolution.
- `branch_valid_ex_i` in 1: a valid branch/jal/jalr is in EX.
- `pc_ex_i` in 32: PC of the EX instruction.
- `branch_taken_ex_i` in 1: actual outcome (1 for jumps).
- `pc_target_ex_i` in 32: actual target.
- `pred_taken_ex_i` in 1: prediction bit piped from fetch to EX.
- `pred_pc_target_ex_i` in 32: predicted target piped from fetch to EX.
- `pc_src_o` out 2: next-PC select for fetch.
- `pred_pc_target_fi_o` out 32: predicted target for `pc_fi_i`.
- `pred_taken_fi_o` out 1: prediction for `pc_fi_i`.
- `mispredict_o` out 1: EX mispredict; the hazard unit flushes FI/DE on it.
- `branch_count_o` out CNT_W: resolved branches.
- `mispredict_count_o` out CNT_W: resolved mispredicts.

## Operation
- Entry fields: `valid`, `tag = pc[31:IDX_W+2]`, `target[31:0]`, `ctr[1:0]`.
- Lookup (combinational on `pc_fi_i`): hit = valid && tag match.
  - `pred_taken_fi_o = hit && ctr[1]`.
  - `pred_pc_target_fi_o` = the entry's target on a hit, else 0.
- Resolution (combinational), `res = branch_valid_ex_i && !stall_ex_i`.
  - `mispredict_o = res && (pred_taken_ex_i != branch_taken_ex_i || (pred_taken_ex_i && branch_taken_ex_i && pred_pc_target_ex_i != pc_target_ex_i))`.
- `pc_src_o` priority, encodings from `control_macros.sv`:
  1. mispredict && taken: `PC_SRC_TARGET_E` (2'b11).
  2. mispredict && !taken: `PC_SRC_SEQ_E` (2'b10).
  3. `pred_taken_fi_o`: `PC_SRC_PRED_F` (2'b01).
  4. Otherwise: `PC_SRC_SEQ_F` (2'b00).
- Update at the clock edge when `res`, indexed by `pc_ex_i`:
  - Hit:
    - Counter moves toward the outcome and saturates at 00 and 11.
    - If taken, write target = `pc_target_ex_i`.
  - Miss and taken: allocate (overwrite) with valid=1, tag, target, ctr=2'b10.
  - Miss and not taken: no write.
- Statistics, updated when `res`:
  - `branch_count_o` increments by 1.
  - `mispredict_count_o` increments by 1 if `mispredict_o`.
  - Both saturate at all-ones; they do not wrap.

## Timing
- Lookup and `pc_src_o` are zero-latency combinational; table state is registered.
- A same-cycle EX update and FI lookup to the same index return the pre-update entry: read-before-write, no bypass.
- An update becomes visible to a lookup in the next cycle.
- Reset (synchronous, any cycle, including mid-update, where reset wins):
  - All `valid` = 0 and all `ctr` = 2'b01.
  - Targets and tags are don't-care.
  - Statistics counters = 0.
- Combinational outputs follow from the reset state:
  - `pred_taken_fi_o` = 0 and `pred_pc_target_fi_o` = 0 in the cycle after reset.
  - `pc_src_o` = 2'b00 unless EX inputs assert a mispredict.
- `stall_ex_i` = 1 forces `mispredict_o` = 0 and blocks all writes and counts.
- Aliasing: a different tag at the same index is a miss, and a taken branch evicts the entry.

## Structure
- Shared package `bp_pkg`:
  - `btb_entry_t` struct (`valid`, `tag`, `target`, `ctr`).
  - Counter constants `CTR_SNT`/`CTR_WNT`/`CTR_WT`/`CTR_ST` = 0..3.
  - Reset counter value.
- The `PC_SRC_*` encodings remain in `control_macros.sv`.
- One sub-module, `btb_table`:
  - Parameterized storage array.
  - Async read port (FI).
  - Sync write port (EX).
  - Synchronous clear of valid bits and counters.
- The top module contains the resolution logic, counter next-state, `pc_src` priority mux and statistics.

## Test plan
- Reset, then `pc_fi_i`=0x100 → `pred_taken_fi_o`=0, `pc_src_o`=2'b00, both counts 0.
- EX branch at 0x100, taken, target 0x200, pred 0 → `mispredict_o`=1, `pc_src_o`=2'b11, `mispredict_count_o`=1. Next cycle `pc_fi_i`=0x100 → `pred_taken_fi_o`=1, target 0x200, `pc_src_o`=2'b01.
- Same branch then not-taken twice with pred matching the counter:
  - 1st: counter 10→01, predicted taken so mispredict, `pc_src_o`=2'b10.
  - 2nd: counter 01→00, lookup not taken, no mispredict.
- Predicted taken to 0x200 but actual target 0x300 → `mispredict_o`=1, `pc_src_o`=2'b11. Entry target becomes 0x300.
- Aliasing with `ENTRIES`=64: 0x100 installed; taken branch at 0x1100 (same index) evicts it → lookup of 0x100 misses.
- Same-cycle update and lookup at 0x100 → old entry returned. `stall_ex_i`=1 with a mispredict condition → `mispredict_o`=0, counts unchanged. Reset asserted during an update → table cleared, counts 0.

Source files
------------

// File: rtl/bp_pkg.sv
// Branch predictor shared types, counter encodings and helpers.
package bp_pkg;

  localparam int TAG_MAX_W = 30;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;
  localparam logic [1:0] CTR_RST = CTR_WNT;

  // Tag is stored right-aligned; upper bits are zero when IDX_W > 0.
  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
  } btb_entry_t;

  // Two-bit saturating counter step toward the resolved outcome.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr + 2'd1;
    end else begin
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/control_macros.sv
// Next-PC select encodings shared by the fetch PC mux and its producers.
package control_macros_pkg;

  localparam logic [1:0] PC_SRC_SEQ_F    = 2'b00;  // fetch PC + 4
  localparam logic [1:0] PC_SRC_PRED_F   = 2'b01;  // predicted target from fetch
  localparam logic [1:0] PC_SRC_SEQ_E    = 2'b10;  // EX PC + 4 (recover not-taken)
  localparam logic [1:0] PC_SRC_TARGET_E = 2'b11;  // EX resolved target

endpackage

// File: rtl/branch_predictor_btb_table.sv
// Direct-mapped BTB storage: two async read ports (fetch, execute), one sync write port.
module btb_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [IDX_W-1:0] rd_fi_idx_i,
  output btb_entry_t       rd_fi_entry_o,
  input  logic [IDX_W-1:0] rd_ex_idx_i,
  output btb_entry_t       rd_ex_entry_o,
  input  logic             we_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  btb_entry_t       wr_entry_i
);

  btb_entry_t entries_q [ENTRIES];
  btb_entry_t entries_d [ENTRIES];

  assign rd_fi_entry_o = entries_q[rd_fi_idx_i];
  assign rd_ex_entry_o = entries_q[rd_ex_idx_i];

  // Next table contents: single-entry write from execute, otherwise hold.
  always_comb begin
    entries_d = entries_q;
    if (we_i) begin
      entries_d[wr_idx_i] = wr_entry_i;
    end else begin
      entries_d = entries_q;
    end
  end

  // Table registers; reset invalidates every entry and returns counters to weakly not-taken.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_RST};
      end
    end else begin
      entries_q <= entries_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: BTB lookup, EX resolution/update, next-PC select, statistics.
module branch_predictor
  import bp_pkg::*;
  import control_macros_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [31:0]      pc_fi_i,
  input  logic             stall_ex_i,
  input  logic             branch_valid_ex_i,
  input  logic [31:0]      pc_ex_i,
  input  logic             branch_taken_ex_i,
  input  logic [31:0]      pc_target_ex_i,
  input  logic             pred_taken_ex_i,
  input  logic [31:0]      pred_pc_target_ex_i,
  output logic [1:0]       pc_src_o,
  output logic [31:0]      pred_pc_target_fi_o,
  output logic             pred_taken_fi_o,
  output logic             mispredict_o,
  output logic [CNT_W-1:0] branch_count_o,
  output logic [CNT_W-1:0] mispredict_count_o
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0]     idx_fi_s, idx_ex_s;
  logic [TAG_MAX_W-1:0] tag_fi_s, tag_ex_s;
  btb_entry_t           entry_fi_s, entry_ex_s, wr_entry_s;
  logic                 hit_fi_s, hit_ex_s, res_s, we_s;
  logic [CNT_W-1:0]     branch_count_d, branch_count_q;
  logic [CNT_W-1:0]     mispredict_count_d, mispredict_count_q;

  assign idx_fi_s = pc_fi_i[IDX_W+1:2];
  assign idx_ex_s = pc_ex_i[IDX_W+1:2];
  assign tag_fi_s = TAG_MAX_W'(pc_fi_i >> (IDX_W + 2));
  assign tag_ex_s = TAG_MAX_W'(pc_ex_i >> (IDX_W + 2));

  btb_table #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_btb (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rd_fi_idx_i   (idx_fi_s),
    .rd_fi_entry_o (entry_fi_s),
    .rd_ex_idx_i   (idx_ex_s),
    .rd_ex_entry_o (entry_ex_s),
    .we_i          (we_s),
    .wr_idx_i      (idx_ex_s),
    .wr_entry_i    (wr_entry_s)
  );

  // Fetch lookup and EX resolution; a stalled EX neither resolves nor flushes.
  always_comb begin
    hit_fi_s            = entry_fi_s.valid && (entry_fi_s.tag == tag_fi_s);
    hit_ex_s            = entry_ex_s.valid && (entry_ex_s.tag == tag_ex_s);
    pred_taken_fi_o     = hit_fi_s && entry_fi_s.ctr[1];
    pred_pc_target_fi_o = hit_fi_s ? entry_fi_s.target : 32'd0;
    res_s               = branch_valid_ex_i && !stall_ex_i;
    mispredict_o        = res_s &&
                          ((pred_taken_ex_i != branch_taken_ex_i) ||
                           (pred_taken_ex_i && branch_taken_ex_i &&
                            (pred_pc_target_ex_i != pc_target_ex_i)));
  end

  // Next-PC select: an EX redirect overrides any fetch prediction.
  always_comb begin
    pc_src_o = PC_SRC_SEQ_F;
    if (mispredict_o && branch_taken_ex_i) begin
      pc_src_o = PC_SRC_TARGET_E;
    end else if (mispredict_o) begin
      pc_src_o = PC_SRC_SEQ_E;
    end else if (pred_taken_fi_o) begin
      pc_src_o = PC_SRC_PRED_F;
    end else begin
      pc_src_o = PC_SRC_SEQ_F;
    end
  end

  // BTB write: train a hit, allocate on a taken miss, skip a not-taken miss.
  always_comb begin
    wr_entry_s = entry_ex_s;
    we_s       = 1'b0;
    if (res_s && hit_ex_s) begin
      we_s              = 1'b1;
      wr_entry_s.ctr    = ctr_next(entry_ex_s.ctr, branch_taken_ex_i);
      wr_entry_s.target = branch_taken_ex_i ? pc_target_ex_i : entry_ex_s.target;
    end else if (res_s && branch_taken_ex_i) begin
      we_s       = 1'b1;
      wr_entry_s = '{valid: 1'b1, tag: tag_ex_s, target: pc_target_ex_i, ctr: CTR_WT};
    end else begin
      we_s       = 1'b0;
    end
  end

  // Saturating statistics next-state.
  always_comb begin
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (res_s && (branch_count_q != {CNT_W{1'b1}})) begin
      branch_count_d = branch_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      branch_count_d = branch_count_q;
    end
    if (mispredict_o && (mispredict_count_q != {CNT_W{1'b1}})) begin
      mispredict_count_d = mispredict_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      mispredict_count_d = mispredict_count_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign branch_count_o     = branch_count_q;
  assign mispredict_count_o = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: driver queues expectations, negedge monitor compares.
module tb_branch_predictor;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [31:0] pc_fi_i;
  logic        stall_ex_i;
  logic        branch_valid_ex_i;
  logic [31:0] pc_ex_i;
  logic        branch_taken_ex_i;
  logic [31:0] pc_target_ex_i;
  logic        pred_taken_ex_i;
  logic [31:0] pred_pc_target_ex_i;
  logic [1:0]  pc_src_o;
  logic [31:0] pred_pc_target_fi_o;
  logic        pred_taken_fi_o;
  logic        mispredict_o;
  logic [31:0] branch_count_o;
  logic [31:0] mispredict_count_o;

  typedef struct {
    int          id;
    logic [1:0]  src;
    logic        mp;
    logic        pt;
    logic [31:0] ptg;
    logic [31:0] bc;
    logic [31:0] mc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  branch_predictor #(.ENTRIES(64), .CNT_W(32)) dut (
    .clk_i               (clk_i),
    .reset_i             (reset_i),
    .pc_fi_i             (pc_fi_i),
    .stall_ex_i          (stall_ex_i),
    .branch_valid_ex_i   (branch_valid_ex_i),
    .pc_ex_i             (pc_ex_i),
    .branch_taken_ex_i   (branch_taken_ex_i),
    .pc_target_ex_i      (pc_target_ex_i),
    .pred_taken_ex_i     (pred_taken_ex_i),
    .pred_pc_target_ex_i (pred_pc_target_ex_i),
    .pc_src_o            (pc_src_o),
    .pred_pc_target_fi_o (pred_pc_target_fi_o),
    .pred_taken_fi_o     (pred_taken_fi_o),
    .mispredict_o        (mispredict_o),
    .branch_count_o      (branch_count_o),
    .mispredict_count_o  (mispredict_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL cyc%0d %s: got 0x%0h expected 0x%0h", id, name, act, exp);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk_i) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(e.id, "pc_src",      {30'd0, pc_src_o},        {30'd0, e.src});
      chk(e.id, "mispredict",  {31'd0, mispredict_o},    {31'd0, e.mp});
      chk(e.id, "pred_taken",  {31'd0, pred_taken_fi_o}, {31'd0, e.pt});
      chk(e.id, "pred_target", pred_pc_target_fi_o,      e.ptg);
      chk(e.id, "br_count",    branch_count_o,           e.bc);
      chk(e.id, "mp_count",    mispredict_count_o,       e.mc);
    end
  end

  // One stimulus cycle with its hand-computed expected outputs.
  task automatic cyc(input int id, input logic rst, input logic [31:0] fi,
                     input logic bv, input logic st, input logic [31:0] pex,
                     input logic tk, input logic [31:0] tgt, input logic pt_ex,
                     input logic [31:0] ptg_ex,
                     input logic [1:0] e_src, input logic e_mp, input logic e_pt,
                     input logic [31:0] e_ptg, input int e_bc, input int e_mc);
    exp_t e;
    @(posedge clk_i);
    #1;
    reset_i             = rst;
    pc_fi_i             = fi;
    branch_valid_ex_i   = bv;
    stall_ex_i          = st;
    pc_ex_i             = pex;
    branch_taken_ex_i   = tk;
    pc_target_ex_i      = tgt;
    pred_taken_ex_i     = pt_ex;
    pred_pc_target_ex_i = ptg_ex;
    e = '{id: id, src: e_src, mp: e_mp, pt: e_pt, ptg: e_ptg, bc: 32'(e_bc), mc: 32'(e_mc)};
    exp_q.push_back(e);
  endtask

  initial begin
    reset_i = 1'b1; pc_fi_i = 32'd0; stall_ex_i = 1'b0; branch_valid_ex_i = 1'b0;
    pc_ex_i = 32'd0; branch_taken_ex_i = 1'b0; pc_target_ex_i = 32'd0;
    pred_taken_ex_i = 1'b0; pred_pc_target_ex_i = 32'd0;
    repeat (2) @(posedge clk_i);
    //  id rst fi          bv st pc_ex       tk tgt         pt ptg_ex       src   mp pt ptg          bc mc
    cyc( 1, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h0,   0, 0); // reset state
    cyc( 2, 0, 32'h0,      1, 0, 32'h100,  1, 32'h200, 0, 32'h0,   2'b11, 1, 0, 32'h0,   0, 0); // miss taken, allocate
    cyc( 3, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b01, 0, 1, 32'h200, 1, 1); // hit, ctr 10
    cyc( 4, 0, 32'h100,    1, 0, 32'h100,  0, 32'h0,   1, 32'h200, 2'b10, 1, 1, 32'h200, 1, 1); // not taken, 10->01
    cyc( 5, 0, 32'h100,    1, 0, 32'h100,  0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h200, 2, 2); // 01->00, correct
    cyc( 6, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h200, 3, 2); // saturated at 00
    cyc( 7, 0, 32'h100,    1, 0, 32'h100,  1, 32'h300, 1, 32'h200, 2'b11, 1, 0, 32'h200, 3, 2); // wrong target
    cyc( 8, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h300, 4, 3); // target now 0x300, ctr 01
    cyc( 9, 0, 32'h100,    1, 0, 32'h100,  1, 32'h300, 0, 32'h0,   2'b11, 1, 0, 32'h300, 4, 3); // 01->10
    cyc(10, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b01, 0, 1, 32'h300, 5, 4);
    cyc(11, 0, 32'h100,    1, 0, 32'h1100, 1, 32'h400, 0, 32'h0,   2'b11, 1, 1, 32'h300, 5, 4); // alias evict, old entry read
    cyc(12, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h0,   6, 5); // 0x100 now misses
    cyc(13, 0, 32'h1100,   0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b01, 0, 1, 32'h400, 6, 5);
    cyc(14, 0, 32'h1100,   1, 1, 32'h1100, 0, 32'h0,   1, 32'h400, 2'b01, 0, 1, 32'h400, 6, 5); // stalled
    cyc(15, 0, 32'h1100,   0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b01, 0, 1, 32'h400, 6, 5); // nothing changed
    cyc(16, 0, 32'h1100,   1, 0, 32'h1100, 1, 32'h400, 1, 32'h400, 2'b01, 0, 1, 32'h400, 6, 5); // correct, 10->11
    cyc(17, 0, 32'h1100,   1, 0, 32'h1100, 1, 32'h400, 1, 32'h400, 2'b01, 0, 1, 32'h400, 7, 5); // stays 11
    cyc(18, 0, 32'h1100,   1, 0, 32'h1100, 0, 32'h0,   1, 32'h400, 2'b10, 1, 1, 32'h400, 8, 5); // 11->10
    cyc(19, 0, 32'h1100,   0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b01, 0, 1, 32'h400, 9, 6); // still taken
    cyc(20, 1, 32'h1100,   1, 0, 32'h1100, 1, 32'h500, 0, 32'h0,   2'b11, 1, 1, 32'h400, 9, 6); // reset mid-update
    cyc(21, 0, 32'h1100,   0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h0,   0, 0); // table cleared
    cyc(22, 0, 32'h100,    1, 0, 32'h100,  0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h0,   0, 0); // not-taken miss: no alloc
    cyc(23, 0, 32'h100,    0, 0, 32'h0,    0, 32'h0,   0, 32'h0,   2'b00, 0, 0, 32'h0,   1, 0);
    @(posedge clk_i);
    #1;
    branch_valid_ex_i = 1'b0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) @(posedge clk_i);
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
